// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;

  // Address width for a given register count; never narrower than one bit.
  function automatic int calc_aw(input int nregs);
    return (nregs > 2) ? $clog2(nregs) : 1;
  endfunction

  localparam int AW_DEF = calc_aw(NREGS_DEF);

  // Register index at the default geometry.
  typedef logic [AW_DEF-1:0] regaddr_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Issue/writeback-side bus of the register file: read ports, write port,
// reserve request and scoreboard status.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = NRD_DEF
) ();

  localparam int AW = calc_aw(NREGS);

  logic              we;
  logic [AW-1:0]     waddr;
  logic [XLEN-1:0]   wdata;
  logic [NRD*AW-1:0] raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]    rbusy;
  logic              rsv_valid;
  logic [AW-1:0]     rsv_addr;
  logic              any_busy;

  // Datapath side: decode/issue and writeback.
  modport master (
    output we, waddr, wdata, raddr, rsv_valid, rsv_addr,
    input  rdata, rbusy, any_busy
  );

  // Register file side.
  modport slave (
    input  we, waddr, wdata, raddr, rsv_valid, rsv_addr,
    output rdata, rbusy, any_busy
  );

endinterface

// File: rtl/regfile_busy_tracker.sv
// Per-register busy scoreboard. Requests arrive already qualified (in range,
// not the hardwired zero register), so this block only applies priority.
module regfile_busy_tracker #(
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_valid,
  input  logic [AW-1:0]    clr_addr,
  input  logic             set_valid,
  input  logic [AW-1:0]    set_addr,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:0] busy_q;

  // Reserve beats writeback on the same register: the new producer supersedes
  // the one completing this cycle.
  // NOTE: state is updated with <= so every bit samples the same pre-edge
  // values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (set_valid && set_addr == AW'(i)) begin
          busy_q[i] <= 1'b1;
        end else if (clr_valid && clr_addr == AW'(i)) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with NRD asynchronous read ports, one write port,
// optional hardwired-zero register 0 and a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward the same-cycle write to matching reads.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = NRD_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);

  localparam int AW = calc_aw(NREGS);

  logic [XLEN-1:0]     regs [NREGS];
  logic [NREGS-1:0]    busy;
  logic                wr_ok;
  logic                rsv_ok;
  logic [NRD*XLEN-1:0] rdata_c;
  logic [NRD-1:0]      rbusy_c;

  // An address names real, writable state: in range and not the zero register.
  function automatic logic reg_live(input logic [AW-1:0] a);
    return (32'(a) < NREGS) && !(ZERO_REG && a == '0);
  endfunction

  assign wr_ok  = bus.we && reg_live(bus.waddr);
  assign rsv_ok = bus.rsv_valid && reg_live(bus.rsv_addr);

  // Data array write port; reset clears every entry.
  // NOTE: resetting the array is deliberate: reads must return 0 after reset,
  // which rules out mapping this storage onto an unresettable RAM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[bus.waddr] <= bus.wdata;
    end
  end

  regfile_busy_tracker #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_busy (
    .clk       (clk),
    .rst       (rst),
    .clr_valid (wr_ok),
    .clr_addr  (bus.waddr),
    .set_valid (rsv_ok),
    .set_addr  (bus.rsv_addr),
    .busy      (busy)
  );

  // Read muxes: out-of-range and zero-register reads return 0 / not busy.
  // NOTE: defaults first so every path assigns every bit and no latch forms.
  always_comb begin
    rdata_c = '0;
    rbusy_c = '0;
    for (int i = 0; i < NRD; i++) begin
      if (reg_live(bus.raddr[i*AW +: AW])) begin
        rdata_c[i*XLEN +: XLEN] = regs[bus.raddr[i*AW +: AW]];
        rbusy_c[i]              = busy[bus.raddr[i*AW +: AW]];
      end
`ifdef REGFILE_BYPASS_EN
      // Forward the accepted write; a same-register reserve keeps it busy.
      if (wr_ok && bus.waddr == bus.raddr[i*AW +: AW]) begin
        rdata_c[i*XLEN +: XLEN] = bus.wdata;
        rbusy_c[i]              = rsv_ok && (bus.rsv_addr == bus.waddr);
      end
`endif
    end
  end

  assign bus.rdata    = rdata_c;
  assign bus.rbusy    = rbusy_c;
  assign bus.any_busy = |busy;

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the processor's 32x32 integer register file.
- Provides NRD asynchronous read ports, one synchronous write port, and an optional hardwired-zero register 0.
- Adds a per-register busy scoreboard. Issue logic reserves a destination; the later writeback clears it.
- Sits between decode/issue (read and reserve) and writeback (write) in the datapath.

Parameters:
- XLEN, 32: data width of each register.
- NREGS, 32: number of architectural registers; minimum 2; need not be a power of two.
- NRD, 2: number of read ports; minimum 1.
- ZERO_REG, 1: 1 means register 0 reads 0, ignores writes and ignores reservations; 0 means register 0 is ordinary.
- AW, $clog2(NREGS): derived address width; not to be overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  XLEN  write data.
- raddr  in  NRD*AW  packed read addresses; port i is bits [i*AW +: AW].
- rdata  out  NRD*XLEN  packed read data; port i is bits [i*XLEN +: XLEN].
- rbusy  out  NRD  busy bit of each read port's register.
- rsv_valid  in  1  reserve request.
- rsv_addr  in  AW  register to mark busy.
- any_busy  out  1  OR of all busy bits.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-low: sampled on the rising edge of clk; rst==0 at an edge clears state.
- Reset effect:
  - Every register clears to 0 and every busy bit clears to 0.
  - After that edge: rdata = 0, rbusy = 0, any_busy = 0.
  - we and rsv_valid are ignored on any edge where rst==0.
  - Reset mid-operation discards all pending reservations.
- Reads:
  - Combinational, zero latency.
  - rdata[i] = reg[raddr[i]] and rbusy[i] = busy[raddr[i]].
  - Address >= NREGS returns rdata 0 and rbusy 0.
  - With ZERO_REG=1, address 0 always returns 0 and not busy.
- Writes: at the rising edge with rst==1 and we==1, reg[waddr] <= wdata. The write is ignored when:
  - waddr >= NREGS, or
  - ZERO_REG=1 and waddr==0.
- Scoreboard, per register (valid address, not zero-register when ZERO_REG=1):
  - Reserve only: busy <= 1.
  - Write only: busy <= 0.
  - Reserve and write to the same register in the same cycle: reserve wins, busy = 1 (a new producer supersedes the completing one).
  - Reserve and write to different registers: both take effect.
  - Reserving an already-busy register: busy stays 1; no counting, single outstanding producer per register.
  - Write to a non-busy register: data is written, busy stays 0.
- any_busy reflects registered busy state only (no forwarding).
- Write-read same register same cycle without bypass: rdata shows the old value; the new value is visible from the next cycle.
- All outputs are driven purely from registered state plus read addresses, except the bypass path below.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: for each read port, when we==1, the write is valid (not ignored per the write rules) and waddr==raddr[i]:
  - rdata[i] = wdata in the same cycle;
  - rbusy[i] = 0, unless rsv_valid targets the same register, in which case rbusy[i] = 1.
- Undefined: no forwarding; reads reflect registered state only. This adds one cycle of visibility latency for writeback-to-read.

Decomposition:
- Package regfile_pkg holds:
  - default constants XLEN_DEF=32, NREGS_DEF=32, NRD_DEF=2;
  - a function computing AW;
  - typedef regaddr_t for the default width.
- Natural sub-module regfile_busy_tracker holds the NREGS busy-bit array and its reserve/clear priority logic, and exports the busy vector. The top instantiates the data array, read muxes and bypass.

Test Plan:
- Reset: write reg3=0xDEADBEEF, reserve reg5, then drive rst=0 for 1 edge -> reg3 reads 0, rbusy=0, any_busy=0.
- Register 0: we=1, waddr=0, wdata=0x12345678 plus rsv_addr=0 with ZERO_REG=1 -> rdata(0)=0, rbusy=0; the same with ZERO_REG=0 -> reads 0x12345678 and busy.
- Scoreboard:
  - reserve reg7 -> rbusy=1, any_busy=1;
  - next cycle write reg7=0xA5A5A5A5 -> busy 0, data 0xA5A5A5A5;
  - simultaneous reserve and write reg7 -> busy remains 1.
- Same-cycle write/read reg9=0x55 while it holds 0x11 -> without the macro, 0x11 then 0x55; with REGFILE_BYPASS_EN, 0x55 immediately and rbusy=0.
- NREGS=24, NRD=3:
  - write addr 30 is ignored and read addr 30 returns 0;
  - all three ports read distinct registers 1, 2, 23 simultaneously and return the written values.
